// File: rtl/mux_4to1_pkg.sv
`default_nettype none
// ============================================================================
// | Module      : mux_4to1_pkg                                               |
// | Description : Shared select-code constants and select typedef for the    |
// |               registered 4-to-1 multiplexer.                             |
// | Contents    : sel_t  - 2-bit select code {S1,S0}                         |
// |               SEL_A..SEL_D - select codes for inputs A..D                |
// |               N_INPUTS - number of data inputs (one-hot enable width)    |
// | Revision    : 1.0 - initial release                                      |
// ============================================================================
package mux_4to1_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_A = 2'b00;
  localparam sel_t SEL_B = 2'b01;
  localparam sel_t SEL_C = 2'b10;
  localparam sel_t SEL_D = 2'b11;

  localparam int N_INPUTS = 4;

endpackage : mux_4to1_pkg
`default_nettype wire

// File: rtl/mux_4to1_sel_decode.sv
`default_nettype none
// ============================================================================
// | Module      : mux_4to1_sel_decode                                        |
// | Description : Converts the 2-bit select code into a one-hot enable       |
// |               vector, bit n enabling data input n (A=0 .. D=3).          |
// | Ports       : i_sel [1:0] - select code {S1,S0}                          |
// |               o_en  [3:0] - one-hot enable                               |
// | Revision    : 1.0 - initial release                                      |
// ============================================================================
module mux_4to1_sel_decode
  import mux_4to1_pkg::*;
(
  input  logic [1:0]          i_sel,
  output logic [N_INPUTS-1:0] o_en
);

  always_comb begin
    o_en = '0;
    unique case (sel_t'(i_sel))
      SEL_A:   o_en = 4'b0001;
      SEL_B:   o_en = 4'b0010;
      SEL_C:   o_en = 4'b0100;
      SEL_D:   o_en = 4'b1000;
      default: o_en = '0;
    endcase
  end

endmodule : mux_4to1_sel_decode
`default_nettype wire

// File: rtl/mux_4to1.sv
`default_nettype none
// ============================================================================
// | Module      : mux_4to1                                                   |
// | Description : Registered 4-to-1 multiplexer with valid handshake.        |
// |               A sample is taken on every rising clk edge where in_valid  |
// |               is high; the selected data, its select code and a one-     |
// |               cycle out_valid pulse appear one cycle later. Outputs hold |
// |               while in_valid is low.                                     |
// | Parameters  : WIDTH - data width, legal range 1..64 (default 1)          |
// | Ports       : clk        - clock, rising edge active                     |
// |               rst        - synchronous active-high reset                 |
// |               A,B,C,D    - data inputs for select 00,01,10,11            |
// |               S0,S1      - select LSB / MSB                              |
// |               in_valid   - input sample valid                            |
// |               muxOUT     - registered selected data                      |
// |               out_valid  - one cycle pulse per accepted sample           |
// |               sel_out    - registered {S1,S0} that produced muxOUT       |
// |               muxPAR     - XOR of all muxOUT bits (optional)             |
// | Options     : MUX_4TO1_PARITY_EN - when defined, adds port muxPAR        |
// | Revision    : 1.0 - initial release                                      |
// ============================================================================
module mux_4to1
  import mux_4to1_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  input  logic             S0,
  input  logic             S1,
  input  logic             in_valid,
  output logic [WIDTH-1:0] muxOUT,
  output logic             out_valid,
  output logic [1:0]       sel_out
`ifdef MUX_4TO1_PARITY_EN
  ,
  output logic             muxPAR
`endif
);

  sel_t                w_sel;
  logic [N_INPUTS-1:0] w_en;
  logic [WIDTH-1:0]    w_data;

  logic [WIDTH-1:0]    r_mux;
  sel_t                r_sel;
  logic                r_vld;

  assign w_sel = {S1, S0};

  mux_4to1_sel_decode u_sel_decode (
    .i_sel (w_sel),
    .o_en  (w_en)
  );

  // AND-OR datapath: exactly one enable is high, so exactly one input
  // contributes to the OR.
  assign w_data = ({WIDTH{w_en[0]}} & A)
                | ({WIDTH{w_en[1]}} & B)
                | ({WIDTH{w_en[2]}} & C)
                | ({WIDTH{w_en[3]}} & D);

  // Data and select registers only load on an accepted sample, so X/Z on
  // the inputs while in_valid is low never reaches the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mux <= '0;
      r_sel <= SEL_A;
      r_vld <= 1'b0;
    end else begin
      r_vld <= in_valid;
      if (in_valid) begin
        r_mux <= w_data;
        r_sel <= w_sel;
      end
    end
  end

  assign muxOUT    = r_mux;
  assign sel_out   = r_sel;
  assign out_valid = r_vld;

`ifdef MUX_4TO1_PARITY_EN
  logic r_par;

  // Parity is computed from the same value loaded into r_mux so that it
  // always describes the muxOUT currently presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_par <= 1'b0;
    end else if (in_valid) begin
      r_par <= ^w_data;
    end
  end

  assign muxPAR = r_par;
`endif

endmodule : mux_4to1
`default_nettype wire

// File: tb/tb_mux_4to1.sv
`default_nettype none
// ============================================================================
// | Module      : tb_mux_4to1                                                |
// | Description : Directed self-checking bench for mux_4to1 (WIDTH=4).       |
// |               Inputs change on the falling edge; outputs are checked on  |
// |               the falling edge after the sampling rising edge.           |
// | Options     : MUX_4TO1_PARITY_EN - also checks muxPAR                    |
// | Revision    : 1.0 - initial release                                      |
// ============================================================================
module tb_mux_4to1;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] A, B, C, D;
  logic             S0, S1;
  logic             in_valid;
  logic [WIDTH-1:0] muxOUT;
  logic             out_valid;
  logic [1:0]       sel_out;
`ifdef MUX_4TO1_PARITY_EN
  logic             muxPAR;
`endif

  int n_checks = 0;
  int n_errors = 0;

  mux_4to1 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .C         (C),
    .D         (D),
    .S0        (S0),
    .S1        (S1),
    .in_valid  (in_valid),
    .muxOUT    (muxOUT),
    .out_valid (out_valid),
    .sel_out   (sel_out)
`ifdef MUX_4TO1_PARITY_EN
    ,
    .muxPAR    (muxPAR)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs and advance to the falling edge after the
  // rising edge that samples them.
  task automatic step(input logic r, input logic v, input logic [1:0] s,
                      input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] c, input logic [3:0] d);
    rst = r; in_valid = v; {S1, S0} = s;
    A = a; B = b; C = c; D = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input logic [3:0] m,
                            input logic [1:0] s, input logic ov, input logic par);
    chk({tag, ".mux"}, 64'(muxOUT), 64'(m));
    chk({tag, ".sel"}, 64'(sel_out), 64'(s));
    chk({tag, ".vld"}, 64'(out_valid), 64'(ov));
`ifdef MUX_4TO1_PARITY_EN
    chk({tag, ".par"}, 64'(muxPAR), 64'(par));
`else
    if (par === 1'bx) $display("unexpected X parity argument in %s", tag);
`endif
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; {S1, S0} = 2'b00;
    A = 4'h1; B = 4'h0; C = 4'h0; D = 4'h0;
    @(negedge clk);

    // Reset held two cycles with a valid sample of A=1 present
    step(1'b1, 1'b1, 2'b00, 4'h1, 4'h0, 4'h0, 4'h0);
    expect_out("rst_c0", 4'h0, 2'b00, 1'b0, 1'b0);
    step(1'b1, 1'b1, 2'b00, 4'h1, 4'h0, 4'h0, 4'h0);
    expect_out("rst_c1", 4'h0, 2'b00, 1'b0, 1'b0);

    // A=1 only, selects 00,10,01,01; first sample after reset
    step(1'b0, 1'b1, 2'b00, 4'h1, 4'h0, 4'h0, 4'h0);
    expect_out("seq1_00", 4'h1, 2'b00, 1'b1, 1'b1);
    step(1'b0, 1'b1, 2'b10, 4'h1, 4'h0, 4'h0, 4'h0);
    expect_out("seq1_10", 4'h0, 2'b10, 1'b1, 1'b0);
    step(1'b0, 1'b1, 2'b01, 4'h1, 4'h0, 4'h0, 4'h0);
    expect_out("seq1_01a", 4'h0, 2'b01, 1'b1, 1'b0);
    step(1'b0, 1'b1, 2'b01, 4'h1, 4'h0, 4'h0, 4'h0);
    expect_out("seq1_01b", 4'h0, 2'b01, 1'b1, 1'b0);

    // A=0,B=1,C=0,D=1 swept back-to-back
    step(1'b0, 1'b1, 2'b00, 4'h0, 4'h1, 4'h0, 4'h1);
    expect_out("sw1_00", 4'h0, 2'b00, 1'b1, 1'b0);
    step(1'b0, 1'b1, 2'b01, 4'h0, 4'h1, 4'h0, 4'h1);
    expect_out("sw1_01", 4'h1, 2'b01, 1'b1, 1'b1);
    step(1'b0, 1'b1, 2'b10, 4'h0, 4'h1, 4'h0, 4'h1);
    expect_out("sw1_10", 4'h0, 2'b10, 1'b1, 1'b0);
    step(1'b0, 1'b1, 2'b11, 4'h0, 4'h1, 4'h0, 4'h1);
    expect_out("sw1_11", 4'h1, 2'b11, 1'b1, 1'b1);

    // Distinct multi-bit values so each input is individually identifiable
    step(1'b0, 1'b1, 2'b00, 4'h3, 4'h5, 4'h8, 4'hE);
    expect_out("sw2_00", 4'h3, 2'b00, 1'b1, 1'b0);
    step(1'b0, 1'b1, 2'b01, 4'h3, 4'h5, 4'h8, 4'hE);
    expect_out("sw2_01", 4'h5, 2'b01, 1'b1, 1'b0);
    step(1'b0, 1'b1, 2'b10, 4'h3, 4'h5, 4'h8, 4'hE);
    expect_out("sw2_10", 4'h8, 2'b10, 1'b1, 1'b1);
    step(1'b0, 1'b1, 2'b11, 4'h3, 4'h5, 4'h8, 4'hE);
    expect_out("sw2_11", 4'hE, 2'b11, 1'b1, 1'b1);

    // Idle for 3 cycles while D changes: outputs hold, out_valid low
    step(1'b0, 1'b0, 2'b11, 4'h3, 4'h5, 4'h8, 4'h0);
    expect_out("idle0", 4'hE, 2'b11, 1'b0, 1'b1);
    step(1'b0, 1'b0, 2'b11, 4'h3, 4'h5, 4'h8, 4'h9);
    expect_out("idle1", 4'hE, 2'b11, 1'b0, 1'b1);
    step(1'b0, 1'b0, 2'b11, 4'h3, 4'h5, 4'h8, 4'hF);
    expect_out("idle2", 4'hE, 2'b11, 1'b0, 1'b1);

    // Accept one more sample, then reset collides with a valid sample
    step(1'b0, 1'b1, 2'b11, 4'h3, 4'h5, 4'h8, 4'h9);
    expect_out("pre_rst", 4'h9, 2'b11, 1'b1, 1'b0);
    step(1'b1, 1'b1, 2'b11, 4'h0, 4'h0, 4'h0, 4'h1);
    expect_out("rst_prio", 4'h0, 2'b00, 1'b0, 1'b0);

    // First sample after reset release: C=0111 selected
    step(1'b0, 1'b1, 2'b10, 4'h0, 4'h0, 4'h7, 4'h0);
    expect_out("post_rst_c", 4'h7, 2'b10, 1'b1, 1'b1);
    step(1'b0, 1'b0, 2'b00, 4'h0, 4'h0, 4'h0, 4'h0);
    expect_out("post_rst_hold", 4'h7, 2'b10, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_mux_4to1
`default_nettype wire
